// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that grants up to N_CDB result requesters per cycle and
// registers the winners onto the common data bus lanes (1-cycle latency).
module cdb_arbiter #(
   parameter int N_REQ         = 4,
   parameter int N_CDB         = 2,
   parameter int ROB_SIZE_CLOG = 5,
   parameter int SRC_LEN       = 5,
   parameter int DATA_LEN      = 32
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic [N_REQ-1:0]                   req_val,
   input  logic [N_REQ*ROB_SIZE_CLOG-1:0]     req_robid,
   input  logic [N_REQ*SRC_LEN-1:0]           req_rd,
   input  logic [N_REQ-1:0]                   req_rfwrite,
   input  logic [N_REQ*DATA_LEN-1:0]          req_data,
   output logic [N_REQ-1:0]                   req_rdy,
   output logic [N_CDB-1:0]                   cdb_val,
   output logic [N_CDB*ROB_SIZE_CLOG-1:0]     cdb_robid,
   output logic [N_CDB*SRC_LEN-1:0]           cdb_rd,
   output logic [N_CDB-1:0]                   cdb_rfwrite,
   output logic [N_CDB*DATA_LEN-1:0]          cdb_data,
   output logic [N_CDB*$clog2(N_REQ)-1:0]     cdb_src
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(N_CDB + 1);

   logic [ROB_SIZE_CLOG-1:0] w_robid [N_REQ];
   logic [SRC_LEN-1:0]       w_rd    [N_REQ];
   logic [DATA_LEN-1:0]      w_data  [N_REQ];
   logic [IW-1:0]            w_lane_src [N_CDB];
   logic [N_CDB-1:0]         w_lane_val;
   logic [N_REQ-1:0]         w_rdy;
   logic [CW-1:0]            w_cnt;
   logic [IW:0]              w_idx;
   logic [IW-1:0]            w_last;
   logic [IW:0]              w_inc;
   logic [IW-1:0]            w_ptr_next;

   logic [IW-1:0]                   r_rr_ptr;
   logic [N_CDB-1:0]                r_cdb_val;
   logic [N_CDB*ROB_SIZE_CLOG-1:0]  r_cdb_robid;
   logic [N_CDB*SRC_LEN-1:0]        r_cdb_rd;
   logic [N_CDB-1:0]                r_cdb_rfwrite;
   logic [N_CDB*DATA_LEN-1:0]       r_cdb_data;
   logic [N_CDB*IW-1:0]             r_cdb_src;

   genvar gi, gk;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign w_robid[gi] = req_robid[gi*ROB_SIZE_CLOG +: ROB_SIZE_CLOG];
         assign w_rd[gi]    = req_rd[gi*SRC_LEN +: SRC_LEN];
         assign w_data[gi]  = req_data[gi*DATA_LEN +: DATA_LEN];
      end
   endgenerate

   // Scan from the rotating pointer; the j-th requester found fills lane j.
   always_comb begin
      w_rdy      = '0;
      w_lane_val = '0;
      w_cnt      = '0;
      w_idx      = '0;
      w_last     = r_rr_ptr;
      for (int k = 0; k < N_CDB; k++) w_lane_src[k] = '0;
      for (int s = 0; s < N_REQ; s++) begin
         w_idx = {1'b0, r_rr_ptr} + (IW+1)'(s);
         if (w_idx >= (IW+1)'(N_REQ)) w_idx = w_idx - (IW+1)'(N_REQ);
         if (rst && !flush && req_val[w_idx[IW-1:0]] && (w_cnt < CW'(N_CDB))) begin
            for (int k = 0; k < N_CDB; k++) begin
               if (w_cnt == CW'(k)) begin
                  w_lane_src[k] = w_idx[IW-1:0];
                  w_lane_val[k] = 1'b1;
               end
            end
            w_rdy[w_idx[IW-1:0]] = 1'b1;
            w_last               = w_idx[IW-1:0];
            w_cnt                = w_cnt + CW'(1);
         end
      end
      w_inc      = {1'b0, w_last} + (IW+1)'(1);
      w_ptr_next = (w_inc == (IW+1)'(N_REQ)) ? '0 : w_inc[IW-1:0];
   end

   assign req_rdy = w_rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr      <= '0;
         r_cdb_val     <= '0;
         r_cdb_robid   <= '0;
         r_cdb_rd      <= '0;
         r_cdb_rfwrite <= '0;
         r_cdb_data    <= '0;
         r_cdb_src     <= '0;
      end else begin
         if (w_cnt != '0) r_rr_ptr <= w_ptr_next;
         r_cdb_val <= w_lane_val;
         for (int k = 0; k < N_CDB; k++) begin
            r_cdb_robid[k*ROB_SIZE_CLOG +: ROB_SIZE_CLOG] <= w_lane_val[k] ? w_robid[w_lane_src[k]] : '0;
            r_cdb_rd[k*SRC_LEN +: SRC_LEN]                <= w_lane_val[k] ? w_rd[w_lane_src[k]] : '0;
            r_cdb_rfwrite[k]                              <= w_lane_val[k] & req_rfwrite[w_lane_src[k]];
            r_cdb_data[k*DATA_LEN +: DATA_LEN]            <= w_lane_val[k] ? w_data[w_lane_src[k]] : '0;
            r_cdb_src[k*IW +: IW]                         <= w_lane_src[k];
         end
      end
   end

   assign cdb_val     = r_cdb_val;
   assign cdb_robid   = r_cdb_robid;
   assign cdb_rd      = r_cdb_rd;
   assign cdb_rfwrite = r_cdb_rfwrite;
   assign cdb_data    = r_cdb_data;
   assign cdb_src     = r_cdb_src;

   // A requester may drive at most one valid lane; stalled payloads must hold.
   logic [N_CDB-1:0] w_hit [N_REQ];
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_chk
         for (gk = 0; gk < N_CDB; gk++) begin : g_lane
            assign w_hit[gi][gk] = r_cdb_val[gk] && (r_cdb_src[gk*IW +: IW] == IW'(gi));
         end
         a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(w_hit[gi]));
         a_rdy_val: assert property (@(posedge clk) disable iff (!rst) !(req_rdy[gi] && !req_val[gi]));
         a_hold: assert property (@(posedge clk) disable iff (!rst)
            (req_val[gi] && !req_rdy[gi] && !flush) |=>
            (req_val[gi] && $stable({w_robid[gi], w_rd[gi], req_rfwrite[gi], w_data[gi]})));
      end
   endgenerate
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random checks of cdb_arbiter (N_REQ=4, N_CDB=2) against a
// round-robin behavioural model plus hand-computed expectations.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int C  = 2;
   localparam int RB = 5;
   localparam int SL = 5;
   localparam int DL = 32;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            flush = 1'b0;
   logic [N-1:0]    req_val = '0;
   logic [N*RB-1:0] req_robid = '0;
   logic [N*SL-1:0] req_rd = '0;
   logic [N-1:0]    req_rfwrite = '0;
   logic [N*DL-1:0] req_data = '0;
   logic [N-1:0]    req_rdy;
   logic [C-1:0]    cdb_val;
   logic [C*RB-1:0] cdb_robid;
   logic [C*SL-1:0] cdb_rd;
   logic [C-1:0]    cdb_rfwrite;
   logic [C*DL-1:0] cdb_data;
   logic [C*IW-1:0] cdb_src;

   cdb_arbiter #(.N_REQ(N), .N_CDB(C), .ROB_SIZE_CLOG(RB), .SRC_LEN(SL), .DATA_LEN(DL)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_val(req_val), .req_robid(req_robid), .req_rd(req_rd),
      .req_rfwrite(req_rfwrite), .req_data(req_data), .req_rdy(req_rdy),
      .cdb_val(cdb_val), .cdb_robid(cdb_robid), .cdb_rd(cdb_rd),
      .cdb_rfwrite(cdb_rfwrite), .cdb_data(cdb_data), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: walk the requesters starting at ptr, first C valid ones win.
   function automatic void pick(input logic [N-1:0] v, input int ptr, input logic blocked,
                                output logic [N-1:0] g, output int l0, output int l1,
                                output int cnt, output int last);
      g = '0; l0 = 0; l1 = 0; cnt = 0; last = ptr;
      if (!blocked) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i] && cnt < C) begin
               g[i] = 1'b1;
               if (cnt == 0) l0 = i; else l1 = i;
               cnt++;
               last = i;
            end
         end
      end
   endfunction

   int          m_ptr;
   logic [C-1:0] m_val;
   int          m_src   [C];
   logic [RB-1:0] m_robid [C];
   logic [SL-1:0] m_rd    [C];
   logic          m_rfw   [C];
   logic [DL-1:0] m_data  [C];

   always @(posedge clk or negedge rst) begin : model
      logic [N-1:0] g;
      int l0, l1, cnt, last;
      if (!rst) begin
         m_ptr <= 0;
         m_val <= '0;
      end else begin
         pick(req_val, m_ptr, flush, g, l0, l1, cnt, last);
         m_val     <= {cnt > 1, cnt > 0};
         m_src[0]  <= l0;                       m_src[1]  <= l1;
         m_robid[0] <= req_robid[l0*RB +: RB];  m_robid[1] <= req_robid[l1*RB +: RB];
         m_rd[0]   <= req_rd[l0*SL +: SL];      m_rd[1]   <= req_rd[l1*SL +: SL];
         m_rfw[0]  <= req_rfwrite[l0];          m_rfw[1]  <= req_rfwrite[l1];
         m_data[0] <= req_data[l0*DL +: DL];    m_data[1] <= req_data[l1*DL +: DL];
         if (cnt > 0) m_ptr <= (last + 1) % N;
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] g;
      int l0, l1, cnt, last;
      pick(req_val, m_ptr, flush || !rst, g, l0, l1, cnt, last);
      chk("req_rdy", req_rdy, g);
      chk("cdb_val", cdb_val, m_val);
      for (int k = 0; k < C; k++) begin
         if (m_val[k]) begin
            chk("cdb_src",     cdb_src[k*IW +: IW],   m_src[k][IW-1:0]);
            chk("cdb_robid",   cdb_robid[k*RB +: RB], m_robid[k]);
            chk("cdb_rd",      cdb_rd[k*SL +: SL],    m_rd[k]);
            chk("cdb_rfwrite", cdb_rfwrite[k],        m_rfw[k]);
            chk("cdb_data",    cdb_data[k*DL +: DL],  m_data[k]);
         end
      end
   end

   localparam logic [31:0] DA = 32'hAAAA_0001, DB = 32'hBBBB_0002, DC = 32'hCCCC_0003, DD = 32'hDDDD_0004;

   int wait_cnt [N];

   initial begin
      // 1: reset holds everything quiet even with all requesters valid
      req_val     = 4'hF;
      req_data    = {DD, DC, DB, DA};
      req_robid   = {5'd4, 5'd3, 5'd2, 5'd1};
      req_rd      = {5'd14, 5'd13, 5'd12, 5'd11};
      req_rfwrite = 4'b0101;
      repeat (2) @(negedge clk);
      #1 chk("t1_rdy", req_rdy, 4'b0000);
      chk("t1_val", cdb_val, 2'b00);
      #1 rst = 1'b1;
      // 2: pointer starts at 0, all four requesting
      #1 chk("t2_rdy_a", req_rdy, 4'b0011);
      @(posedge clk); #1 req_val = 4'b1100;
      @(negedge clk); #1 chk("t2_rdy_b", req_rdy, 4'b1100);
      chk("t2_data_ba", cdb_data, {DB, DA});
      chk("t2_src_10", cdb_src, {2'd1, 2'd0});
      @(posedge clk); #1 req_val = 4'b0000;
      @(negedge clk); #1 chk("t2_data_dc", cdb_data, {DD, DC});
      chk("t2_src_32", cdb_src, {2'd3, 2'd2});
      chk("t2_val", cdb_val, 2'b11);
      // 3: single requester 3, robid 9, pointer wraps back to 0
      req_robid[3*RB +: RB] = 5'd9;
      req_val = 4'b1000;
      #1 chk("t3_rdy", req_rdy, 4'b1000);
      @(posedge clk); #1 req_val = 4'b0000;
      @(negedge clk); #1 chk("t3_val", cdb_val, 2'b01);
      chk("t3_robid", cdb_robid[RB-1:0], 5'd9);
      chk("t3_src", cdb_src[IW-1:0], 2'd3);
      // 4: move pointer to 3, then requesters 3 and 0 wrap
      req_val = 4'b0100;
      @(posedge clk); #1 req_val = 4'b1001;
      #1 chk("t4_rdy", req_rdy, 4'b1001);
      @(posedge clk); #1 req_val = 4'b0000;
      @(negedge clk); #1 chk("t4_src", cdb_src, {2'd0, 2'd3});
      chk("t4_val", cdb_val, 2'b11);
      req_val = 4'hF;
      #1 chk("t4_ptr1", req_rdy, 4'b0110);
      req_val = 4'b0010;
      @(posedge clk); #1;
      // 5: pointer is 2; flush blocks grants and holds the pointer
      flush = 1'b1; req_val = 4'hF;
      #1 chk("t5_rdy", req_rdy, 4'b0000);
      @(posedge clk); #1 chk("t5_val", cdb_val, 2'b00);
      chk("t5_rdy2", req_rdy, 4'b0000);
      flush = 1'b0;
      #1 chk("t5_release", req_rdy, 4'b1100);
      @(posedge clk); #1 req_val = 4'b0011;
      @(posedge clk); #1 req_val = 4'b0000;
      // 6: asynchronous reset wipes the bus between edges
      chk("t6_pre", cdb_val, 2'b11);
      #1 rst = 1'b0;
      #1 chk("t6_val", cdb_val, 2'b00);
      chk("t6_data", cdb_data, 64'd0);
      #1 rst = 1'b1;
      req_val = 4'hF;
      #1 chk("t6_ptr0", req_rdy, 4'b0011);

      // Random traffic: stalled requesters hold; each must win within 2 cycles
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      for (int c = 0; c < 2000; c++) begin
         logic [N-1:0] g;
         int l0, l1, cnt, last;
         pick(req_val, m_ptr, 1'b0, g, l0, l1, cnt, last);
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (req_val[i] && !g[i]) begin
               wait_cnt[i]++;
            end else begin
               if (req_val[i]) chk("fair_wait", wait_cnt[i] > 1, 1'b0);
               wait_cnt[i] = 0;
               req_val[i]  = 1'($urandom_range(0, 1));
               req_robid[i*RB +: RB] = 5'($urandom());
               req_rd[i*SL +: SL]    = 5'($urandom());
               req_rfwrite[i]        = 1'($urandom_range(0, 1));
               req_data[i*DL +: DL]  = $urandom();
            end
         end
      end
      req_val = '0;
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
